// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, frame constants and bit-timing helpers for the UART transmitter
// Frame shape depends on UART_TX_PARITY_EN (see rtl/uart_tx.sv).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_t;

  function automatic int calc_clks_per_bit(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return int'(clk_freq / baud_rate);
  endfunction

  // Clamped to 1 so an illegal divider still elaborates far enough to hit the config check.
  function automatic int calc_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, ticks on the last clock of each bit period
// Counts 0..CLKS_PER_BIT-1, wraps on tick, held at zero while clr_i is high.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10,
  parameter int CNT_W        = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, one byte per request as an 8N1 frame with a done pulse
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTxStart,
  input  logic [7:0] iTxByte,
  output logic       oTxSerial,
  output logic       oTxDone
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_divider
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2 clocks per bit");
    end
  endgenerate

  uart_state_t          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic                 tick;
  logic                 cnt_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // Holding the counter in IDLE/DONE makes the first bit period start cleanly at accept.
  assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_cnt (
    .clk_i (iClk),
    .rst_ni(iRst),
    .clr_i (cnt_clr),
    .tick_o(tick)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q   <= ST_IDLE;
      oTxSerial <= 1'b1;
      oTxDone   <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      oTxDone <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          oTxSerial <= 1'b1;
          if (iTxStart) begin
            shift_q   <= iTxByte;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^iTxByte;
`endif
            oTxSerial <= 1'b0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            oTxSerial <= shift_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              oTxSerial <= parity_q;
              state_q   <= ST_PARITY;
`else
              oTxSerial <= 1'b1;
              state_q   <= ST_STOP;
`endif
            end else begin
              // Next level comes from bit 1 because the shift lands on the same edge.
              oTxSerial <= shift_q[1];
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            oTxSerial <= 1'b1;
            state_q   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            oTxSerial <= 1'b1;
            oTxDone   <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          oTxSerial <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          oTxSerial <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (CLKS_PER_BIT=10, 4 ns clock)
// Honours UART_TX_PARITY_EN for frame length and expected line patterns.
module tb_uart_tx;

  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] EXP_56 = 11'b10010101100;
  localparam logic [10:0] EXP_57 = 11'b11010101110;
  localparam logic [10:0] EXP_00 = 11'b10000000000;
  localparam logic [10:0] EXP_FF = 11'b10111111110;
`else
  localparam int NB = 10;
  localparam logic [10:0] EXP_56 = 11'b01010101100;
  localparam logic [10:0] EXP_57 = 11'b01010101110;
  localparam logic [10:0] EXP_00 = 11'b01000000000;
  localparam logic [10:0] EXP_FF = 11'b01111111110;
`endif

  logic       iClk;
  logic       iRst;
  logic       iTxStart;
  logic [7:0] iTxByte;
  logic       oTxSerial;
  logic       oTxDone;

  int tests;
  int fails;

  uart_tx #(
    .CLK_FREQ (100),
    .BAUD_RATE(10)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iTxStart (iTxStart),
    .iTxByte  (iTxByte),
    .oTxSerial(oTxSerial),
    .oTxDone  (oTxDone)
  );

  initial iClk = 1'b0;
  always #2 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Raise start now; it is accepted at the next edge. Returns 1 ns after that edge.
  task automatic start_byte(input logic [7:0] b);
    iTxStart = 1'b1;
    iTxByte  = b;
    step();
    iTxStart = 1'b0;
    iTxByte  = 8'h00;
  endtask

  // Called 1 ns after the accepting edge; checks every bit level, then the done pulse.
  task automatic check_frame(input logic [10:0] exp, input string name, input bit inject);
    logic [C-1:0] obs;
    logic         done_seen;
    done_seen = 1'b0;
    for (int j = 0; j < NB; j++) begin
      for (int c = 0; c < C; c++) begin
        obs[c]    = oTxSerial;
        done_seen = done_seen | oTxDone;
        if (inject && j == 4 && c == 0) begin
          iTxStart = 1'b1;
          iTxByte  = 8'hFF;
        end else if (inject && j == 4 && c == 1) begin
          iTxStart = 1'b0;
          iTxByte  = 8'h00;
        end
        step();
      end
      tests++;
      if (obs !== {C{exp[j]}}) begin
        fails++;
        $display("FAIL %s bit%0d: got %b want %b", name, j, obs, {C{exp[j]}});
      end
    end
    tests++;
    if (done_seen !== 1'b0) begin
      fails++;
      $display("FAIL %s early_done: got %b want 0", name, done_seen);
    end
    tests++;
    if (oTxDone !== 1'b1 || oTxSerial !== 1'b1) begin
      fails++;
      $display("FAIL %s done_pulse: got done=%b line=%b want done=1 line=1", name, oTxDone, oTxSerial);
    end
    step();
    tests++;
    if (oTxDone !== 1'b0 || oTxSerial !== 1'b1) begin
      fails++;
      $display("FAIL %s done_width: got done=%b line=%b want done=0 line=1", name, oTxDone, oTxSerial);
    end
  endtask

  task automatic test_reset();
    logic bad;
    bad      = 1'b0;
    iRst     = 1'b0;
    iTxStart = 1'b1;
    iTxByte  = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      step();
      if (oTxSerial !== 1'b1 || oTxDone !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got bad=%b want 0", bad);
    end
    iTxStart = 1'b0;
    iRst     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oTxSerial !== 1'b1 || oTxDone !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got bad=%b want 0", bad);
    end
  endtask

  task automatic test_single_frame();
    step();
    start_byte(8'h56);
    check_frame(EXP_56, "frame_56", 1'b0);
  endtask

  task automatic test_ignore_start();
    step();
    start_byte(8'h56);
    check_frame(EXP_56, "ignore_start", 1'b1);
    for (int i = 0; i < 3 * C; i++) begin
      step();
    end
    tests++;
    if (oTxSerial !== 1'b1 || oTxDone !== 1'b0) begin
      fails++;
      $display("FAIL ignore_no_queue: got line=%b done=%b want line=1 done=0", oTxSerial, oTxDone);
    end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    bad = 1'b0;
    step();
    start_byte(8'h56);
    for (int i = 0; i < 4 * C + 5; i++) begin
      step();
    end
    tests++;
    if (oTxSerial !== 1'b0) begin
      fails++;
      $display("FAIL abort_pre_bit3: got %b want 0", oTxSerial);
    end
    iRst = 1'b0;
    #1;
    tests++;
    if (oTxSerial !== 1'b1 || oTxDone !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: got line=%b done=%b want line=1 done=0", oTxSerial, oTxDone);
    end
    step();
    step();
    iRst = 1'b1;
    for (int i = 0; i < 12 * C; i++) begin
      step();
      if (oTxSerial !== 1'b1 || oTxDone !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet: got bad=%b want 0", bad);
    end
    start_byte(8'h56);
    check_frame(EXP_56, "after_abort", 1'b0);
  endtask

  task automatic test_back_to_back();
    step();
    start_byte(8'h00);
    check_frame(EXP_00, "b2b_00", 1'b0);
    start_byte(8'hFF);
    check_frame(EXP_FF, "b2b_FF", 1'b0);
  endtask

  task automatic test_parity_pattern();
    step();
    start_byte(8'h57);
    check_frame(EXP_57, "frame_57", 1'b0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    iRst     = 1'b0;
    iTxStart = 1'b0;
    iTxByte  = 8'h00;
    test_reset();
    test_single_frame();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_parity_pattern();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
